// File: rtl/dht11_report_fmt.sv
// dht11_report_fmt: BCD DHT11 reading -> 16-byte ASCII frame over valid/ready, rate-limited; DHT11_FMT_CHANGE_ONLY_EN drops unchanged readings
module dht11_report_fmt #(
  parameter int CLK_FRE   = 50,
  parameter int REPORT_MS = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] data_in,
  input  logic        data_valid,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  input  logic        tx_data_ready,
  output logic        busy,
  output logic [15:0] frame_cnt
);
  localparam int HOLD_CYC = REPORT_MS * CLK_FRE * 1000;
  localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;
  state_t state, state_n;
  logic [23:0] snap, pend, start_data;
  logic pending, start, acc, expire, last_byte;
  logic [3:0] idx;
  logic [CW-1:0] cnt;
`ifdef DHT11_FMT_CHANGE_ONLY_EN
  logic [23:0] last;
  logic last_ok;
`endif
  function automatic logic [7:0] dig(input logic [3:0] n);
    return (n > 4'd9) ? 8'h3F : 8'h30 + {4'h0, n};
  endfunction
  function automatic logic [7:0] fbyte(input logic [23:0] d, input logic [3:0] i);
    case (i)
      4'd0:    fbyte = 8'h54;
      4'd1:    fbyte = 8'h3D;
      4'd2:    fbyte = dig(d[23:20]);
      4'd3:    fbyte = dig(d[19:16]);
      4'd4:    fbyte = 8'h2E;
      4'd5:    fbyte = dig(d[15:12]);
      4'd6:    fbyte = dig(d[11:8]);
      4'd7:    fbyte = 8'h43;
      4'd8:    fbyte = 8'h20;
      4'd9:    fbyte = 8'h48;
      4'd10:   fbyte = 8'h3D;
      4'd11:   fbyte = dig(d[7:4]);
      4'd12:   fbyte = dig(d[3:0]);
      4'd13:   fbyte = 8'h25;
      4'd14:   fbyte = 8'h0D;
      default: fbyte = 8'h0A;
    endcase
  endfunction
  always_comb begin
    acc = tx_data_valid & tx_data_ready;
    last_byte = acc && idx == 4'd15;
    expire = state == HOLD && cnt == CW'(HOLD_CYC - 1);
    // fresh data at expiry beats the older pending value
    start_data = data_valid ? data_in : pend;
    start = (state == IDLE && data_valid) || (expire && (data_valid || pending));
`ifdef DHT11_FMT_CHANGE_ONLY_EN
    if (last_ok && start_data == last) start = 1'b0;
`endif
    state_n = start ? SEND : last_byte ? HOLD : (expire || state == IDLE) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap <= '0;
      pend <= '0;
      pending <= 1'b0;
      idx <= '0;
      cnt <= '0;
      tx_data <= 8'h00;
      tx_data_valid <= 1'b0;
      busy <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (data_valid && state != IDLE && !expire) begin
        pend <= data_in;
        pending <= 1'b1;
      end
      if (expire) pending <= 1'b0;
      cnt <= (state == HOLD) ? cnt + 1'b1 : '0;
      busy <= state_n != IDLE;
      if (start) begin
        snap <= start_data;
        idx <= '0;
        tx_data <= fbyte(start_data, 4'd0);
        tx_data_valid <= 1'b1;
      end else if (acc) begin
        idx <= idx + 4'd1;
        if (last_byte) begin
          tx_data_valid <= 1'b0;
          frame_cnt <= frame_cnt + 16'd1;
        end else tx_data <= fbyte(snap, idx + 4'd1);
      end
    end
  end
`ifdef DHT11_FMT_CHANGE_ONLY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= '0;
      last_ok <= 1'b0;
    end else if (start) begin
      last <= start_data;
      last_ok <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_dht11_report_fmt.sv
// tb_dht11_report_fmt: random-stimulus bench comparing streamed frames against a string-level model
module tb_dht11_report_fmt;
  logic clk = 0, rst_n = 0, data_valid = 0, tx_data_ready = 0;
  logic [23:0] data_in = 0;
  logic [7:0] tx_data;
  logic tx_data_valid, busy;
  logic [15:0] frame_cnt;
  int tests = 0, fails = 0, cyc = 0, mode = 0, stall_err = 0, send_cyc = 0;
  byte got[$];
  int acc_cyc[$], rise_cyc[$];
  logic pv = 0, pr = 0;
  logic [7:0] pd = 0;

  dht11_report_fmt #(.CLK_FRE(1), .REPORT_MS(1)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
    .busy(busy), .frame_cnt(frame_cnt));

  always #5 clk = ~clk;
  always @(negedge clk)
    tx_data_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));

  always @(posedge clk) begin
    if (rst_n) begin
      if (pv && !pr && (!tx_data_valid || tx_data !== pd)) stall_err++;
      if (tx_data_valid && !pv) rise_cyc.push_back(cyc - 1);
      if (tx_data_valid && tx_data_ready) begin
        got.push_back(tx_data);
        acc_cyc.push_back(cyc);
      end
    end
    pv = rst_n & tx_data_valid;
    pr = tx_data_ready;
    pd = tx_data;
    cyc++;
  end

  function automatic string dg(input logic [3:0] n);
    return n < 10 ? $sformatf("%0d", n) : "?";
  endfunction
  function automatic string model(input logic [23:0] d);
    return {"T=", dg(d[23:20]), dg(d[19:16]), ".", dg(d[15:12]), dg(d[11:8]), "C H=",
            dg(d[7:4]), dg(d[3:0]), "%\r\n"};
  endfunction
  function automatic string got_str(input int b);
    string s = "";
    for (int i = 0; i < 16; i++) s = $sformatf("%s%c", s, got[b+i]);
    return s;
  endfunction
  function automatic string vis(input string s);
    string r = s;
    for (int i = 0; i < r.len(); i++) if (r[i] < 8'd32) r[i] = 8'h7E;
    return r;
  endfunction

  task automatic send(input logic [23:0] d);
    @(negedge clk);
    data_in = d;
    data_valid = 1;
    send_cyc = cyc;
    @(negedge clk);
    data_valid = 0;
    data_in = 24'($urandom);
  endtask
  task automatic wait_bytes(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (got.size() >= n) begin ok = 1; return; end
      @(negedge clk);
    end
    ok = got.size() >= n;
  endtask
  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin ok = 1; return; end
      @(negedge clk);
    end
    ok = !busy;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    tests++;
    if (tx_data !== 8'h00 || tx_data_valid !== 1'b0) begin
      fails++; $display("FAIL reset_tx: data=%h valid=%b, want 00/0", tx_data, tx_data_valid);
    end
    tests++;
    if (busy !== 1'b0 || frame_cnt !== 16'd0) begin
      fails++; $display("FAIL reset_state: busy=%b frame_cnt=%0d, want 0/0", busy, frame_cnt);
    end
    rst_n = 1;
  endtask

  task automatic test_basic;
    int b;
    bit ok;
    mode = 0;
    b = got.size();
    send(24'h253060);
    tests++;
    if (tx_data_valid !== 1'b1 || tx_data !== 8'h54) begin
      fails++; $display("FAIL first_byte: valid=%b data=%h, want 1/54", tx_data_valid, tx_data);
    end
    wait_bytes(b + 16, 100, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL basic_timeout: got %0d bytes, want %0d", got.size() - b, 16); end
    else begin
      tests++;
      if (got_str(b) != model(24'h253060)) begin
        fails++; $display("FAIL basic_frame: got '%s' want '%s'", vis(got_str(b)), vis(model(24'h253060)));
      end
      tests++;
      if (acc_cyc[b+15] - acc_cyc[b] != 15 || rise_cyc[$] != send_cyc) begin
        fails++; $display("FAIL basic_timing: span=%0d rise=%0d, want 15 rise=%0d",
                          acc_cyc[b+15] - acc_cyc[b], rise_cyc[$], send_cyc);
      end
    end
    tests++;
    if (frame_cnt !== 16'd1 || tx_data_valid !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL basic_end: frame_cnt=%0d valid=%b busy=%b, want 1/0/1", frame_cnt, tx_data_valid, busy);
    end
    wait_idle(1100, ok);
  endtask

  task automatic test_stall;
    int b;
    bit ok;
    mode = 1;
    stall_err = 0;
    b = got.size();
    send(24'h190045);
    wait_bytes(b + 16, 200, ok);
    tests++;
    if (!ok || got_str(b) != model(24'h190045)) begin
      fails++; $display("FAIL stall_frame: got '%s' want '%s'", vis(got_str(b)), vis(model(24'h190045)));
    end
    tests++;
    if (stall_err != 0) begin fails++; $display("FAIL stall_stable: %0d changes while stalled, want 0", stall_err); end
    wait_idle(1100, ok);
    mode = 0;
  endtask

  task automatic test_pending;
    int b, fc;
    bit ok;
    mode = 0;
    b = got.size();
    fc = frame_cnt;
    send(24'h300070);
    wait_bytes(b + 16, 100, ok);
    send(24'h210050);
    repeat (5) @(negedge clk);
    send(24'h220055);
    wait_bytes(b + 32, 1200, ok);
    tests++;
    if (!ok || got_str(b + 16) != model(24'h220055)) begin
      fails++; $display("FAIL pending_frame: got '%s' want '%s'", vis(got_str(b + 16)), vis(model(24'h220055)));
    end
    tests++;
    if (!ok || rise_cyc[$] - acc_cyc[b+15] != 1000) begin
      fails++; $display("FAIL holdoff_gap: gap=%0d, want 1000", rise_cyc[$] - acc_cyc[b+15]);
    end
    wait_idle(1200, ok);
    tests++;
    if (got.size() != b + 32 || frame_cnt !== 16'(fc + 2)) begin
      fails++; $display("FAIL pending_count: bytes=%0d frames=%0d, want 32/%0d", got.size() - b, frame_cnt, fc + 2);
    end
  endtask

  task automatic test_expiry_race;
    int b, a;
    bit ok;
    mode = 0;
    b = got.size();
    send(24'h111111);
    wait_bytes(b + 16, 100, ok);
    a = acc_cyc[b+15];
    send(24'h121212);
    while (cyc < a + 1000) @(negedge clk);
    data_in = 24'h131313;
    data_valid = 1;
    @(negedge clk);
    data_valid = 0;
    wait_bytes(b + 32, 200, ok);
    tests++;
    if (!ok || got_str(b + 16) != model(24'h131313) || rise_cyc[$] != a + 1000) begin
      fails++; $display("FAIL expiry_race: got '%s' rise=%0d, want '%s' rise=%0d",
                        vis(got_str(b + 16)), rise_cyc[$], vis(model(24'h131313)), a + 1000);
    end
    wait_idle(1200, ok);
    tests++;
    if (got.size() != b + 32) begin
      fails++; $display("FAIL race_pending_cleared: bytes=%0d, want 32", got.size() - b);
    end
  endtask

  task automatic test_bad_digits;
    int b;
    bit ok;
    b = got.size();
    send(24'hA5F03C);
    wait_bytes(b + 16, 100, ok);
    tests++;
    if (!ok || got_str(b) != model(24'hA5F03C)) begin
      fails++; $display("FAIL bad_digits: got '%s' want '%s'", vis(got_str(b)), vis(model(24'hA5F03C)));
    end
    wait_idle(1100, ok);
  endtask

  task automatic test_reset_mid;
    int b;
    bit ok;
    mode = 0;
    b = got.size();
    send(24'h253060);
    wait_bytes(b + 7, 100, ok);
    rst_n = 0;
    #1;
    tests++;
    if (tx_data_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd0) begin
      fails++; $display("FAIL async_reset: valid=%b busy=%b frame_cnt=%0d, want 0/0/0", tx_data_valid, busy, frame_cnt);
    end
    @(negedge clk);
    rst_n = 1;
    b = got.size();
    send(24'h123456);
    wait_bytes(b + 16, 100, ok);
    tests++;
    if (!ok || got_str(b) != model(24'h123456) || frame_cnt !== 16'd1) begin
      fails++; $display("FAIL reset_restart: got '%s' frames=%0d, want '%s' 1",
                        vis(got_str(b)), frame_cnt, vis(model(24'h123456)));
    end
    wait_idle(1100, ok);
  endtask

  task automatic test_random;
    int b, fc;
    bit ok;
    logic [23:0] d;
    mode = 2;
    stall_err = 0;
    for (int i = 0; i < 5; i++) begin
      d = 24'($urandom);
      b = got.size();
      fc = frame_cnt;
      send(d);
      wait_bytes(b + 16, 300, ok);
      tests++;
      if (!ok || got_str(b) != model(d) || frame_cnt !== 16'(fc + 1)) begin
        fails++; $display("FAIL random_%0d: data=%h got '%s' want '%s' frames=%0d", i, d,
                          vis(got_str(b)), vis(model(d)), frame_cnt);
      end
      wait_idle(1200, ok);
    end
    tests++;
    if (stall_err != 0) begin fails++; $display("FAIL random_stable: %0d changes while stalled, want 0", stall_err); end
    mode = 0;
  endtask

  task automatic test_repeat;
    int b, fc;
    bit ok;
    mode = 0;
    b = got.size();
    fc = frame_cnt;
    send(24'h253060);
    wait_bytes(b + 16, 100, ok);
    wait_idle(1200, ok);
    send(24'h253060);
    repeat (1100) @(negedge clk);
`ifdef DHT11_FMT_CHANGE_ONLY_EN
    tests++;
    if (got.size() != b + 16 || frame_cnt !== 16'(fc + 1) || busy !== 1'b0) begin
      fails++; $display("FAIL repeat_dropped: bytes=%0d frames=%0d busy=%b, want 16/%0d/0",
                        got.size() - b, frame_cnt, busy, fc + 1);
    end
    send(24'h253061);
    wait_bytes(b + 32, 100, ok);
    tests++;
    if (!ok || got_str(b + 16) != model(24'h253061) || frame_cnt !== 16'(fc + 2)) begin
      fails++; $display("FAIL change_sent: got '%s' frames=%0d, want '%s' %0d",
                        vis(got_str(b + 16)), frame_cnt, vis(model(24'h253061)), fc + 2);
    end
`else
    tests++;
    if (got.size() != b + 32 || got_str(b + 16) != model(24'h253060) || frame_cnt !== 16'(fc + 2)) begin
      fails++; $display("FAIL repeat_sent: bytes=%0d frames=%0d, want 32/%0d", got.size() - b, frame_cnt, fc + 2);
    end
`endif
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_pending();
    test_expiry_race();
    test_bad_digits();
    test_reset_mid();
    test_random();
    test_repeat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
